// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width defaults, requester FSM encoding, timer sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_t;

    // Width needed to count up to cycles without wrapping; never narrower than 1 bit.
    function automatic int timer_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus signals between the requester and its environment.
// Latency: n/a (wiring only).
// Backpressure: cmd valid/ready, rsp valid/ready, APB completion via pready.
interface apb_master_if #(
    parameter int ADDR_WIDTH = apb_pkg::APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = apb_pkg::APB_DATA_WIDTH
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_write;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, pwrite, pwdata, psel, penable
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, pwrite, pwdata, psel, penable
    );
endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for pready; flags the last allowed cycle.
// Latency: expired is combinational from the registered count.
// Backpressure: none; saturates instead of wrapping, never expires when TIMEOUT_CYCLES is 0.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int             W       = timer_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0]   CNT_MAX = '1;
    localparam logic [W-1:0]   LIMIT   = (TIMEOUT_CYCLES == 0) ? '0 : W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Wait counter: cleared on entry to ACCESS, counts stalled cycles, saturates at all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end
    end

    // Pre-increment compare: the cycle seen with count == LIMIT is the last one allowed.
    assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP and ACCESS, response on valid/ready.
// Latency: accept at T, psel at T+1, penable at T+2, response valid at T+3 best case.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready; pready wait bounded by timer.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    apb_master_if.master    bus
);
    apb_master_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .clear     (timer_clear),
        .enable    (timer_enable),
        .expired   (timer_expired)
    );

    // State and every bus/response output are registered; reset wins over everything.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next state and next register values; everything holds unless the phase changes it.
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        timer_clear   = 1'b0;
        timer_enable  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d   = bus.cmd_addr;
                    pwrite_d  = bus.cmd_write;
                    pwdata_d  = bus.cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d   = 1'b1;
                timer_clear = 1'b1;
                state_d     = ACCESS;
            end
            ACCESS: begin
                // Completion is checked first so a late pready still beats the timeout.
                if (bus.pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
                    rsp_err_d     = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else begin
                    timer_enable = 1'b1;
                    if (timer_expired) begin
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready   = (state_q == IDLE) & i_reset_n;
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a 4-cycle timeout; the bench plays the APB slave.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: rsp_ready and pready driven per scenario.
module tb_apb_master;
    import apb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for ready, and let edge T accept it.
    task automatic send_cmd(input logic [31:0] a, input logic w, input logic [31:0] d);
        int n;
        n = 0;
        bus.cmd_addr  = a;
        bus.cmd_write = w;
        bus.cmd_wdata = d;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_accept_wait ready=%0b required=1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Consume the pending response and confirm the requester is free again.
    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_handshake rsp_valid=%0b cmd_ready=%0b required 0/1", tag, bus.rsp_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_write = 0; bus.cmd_wdata = '0;
        bus.rsp_ready = 0; bus.prdata = '0; bus.pready = 0; bus.pslverr = 0;
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.pwrite, bus.rsp_err, bus.rsp_timeout} !== 6'b0 ||
            bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs psel=%0b penable=%0b rsp_valid=%0b paddr=%h required all zero",
                     bus.psel, bus.penable, bus.rsp_valid, bus.paddr);
        end
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_cmd_ready got=%0b required=0", bus.cmd_ready);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%0b required=1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_fast();
        bus.pready = 1'b1;
        send_cmd(32'h3, 1'b1, 32'hDEADBEEF);
        checks++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.paddr !== 32'h3 ||
            bus.pwrite !== 1'b1 || bus.pwdata !== 32'hDEADBEEF || bus.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL wr_setup psel=%0b penable=%0b paddr=%h pwrite=%0b pwdata=%h required 1/0/3/1/deadbeef",
                     bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata);
        end
        tick();
        checks++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_access psel=%0b penable=%0b rsp_valid=%0b required 1/1/0",
                     bus.psel, bus.penable, bus.rsp_valid);
        end
        tick();
        bus.pready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0 ||
            bus.rsp_rdata !== 32'h0 || bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
            failures++;
            $display("FAIL wr_resp valid=%0b err=%0b timeout=%0b rdata=%h psel=%0b required 1/0/0/0/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, bus.psel);
        end
        finish_rsp("wr");
    endtask

    task automatic test_read_wait();
        bus.pready = 1'b0;
        bus.prdata = 32'hDEADBEEF;
        send_cmd(32'h3, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.psel !== 1'b1 || bus.penable !== 1'b1 || bus.paddr !== 32'h3 ||
                bus.pwrite !== 1'b0 || bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rd_wait_stable cycle=%0d psel=%0b penable=%0b paddr=%h pwrite=%0b rsp_valid=%0b required 1/1/3/0/0",
                         i, bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.rsp_valid);
            end
            if (i == 3) bus.pready = 1'b1;
            tick();
        end
        bus.pready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_err !== 1'b0 ||
            bus.rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL rd_wait_resp valid=%0b rdata=%h err=%0b timeout=%0b required 1/deadbeef/0/0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
        end
        finish_rsp("rd_wait");
    endtask

    task automatic test_slverr();
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        bus.prdata  = 32'h12345678;
        send_cmd(32'h20, 1'b0, 32'h0);
        tick();
        tick();
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_timeout !== 1'b0 ||
            bus.rsp_rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL slverr_resp valid=%0b err=%0b timeout=%0b rdata=%h required 1/1/0/12345678",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
        end
        finish_rsp("slverr");
    endtask

    task automatic test_timeout();
        bus.pready = 1'b0;
        bus.prdata = 32'h55AA55AA;
        send_cmd(32'h40, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.psel !== 1'b1 || bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait cycle=%0d psel=%0b rsp_valid=%0b required 1/0",
                         i, bus.psel, bus.rsp_valid);
            end
            tick();
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_timeout !== 1'b1 ||
            bus.rsp_rdata !== 32'h0 || bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort valid=%0b err=%0b timeout=%0b rdata=%h psel=%0b penable=%0b required 1/1/1/0/0/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, bus.psel, bus.penable);
        end
        finish_rsp("timeout");
    endtask

    task automatic test_rsp_backpressure();
        bus.pready = 1'b1;
        bus.prdata = 32'hCAFEF00D;
        send_cmd(32'h10, 1'b0, 32'h0);
        tick();
        tick();
        bus.pready = 1'b0;
        bus.prdata = 32'h0BADBAD0;
        bus.cmd_addr  = 32'h44;
        bus.cmd_write = 1'b1;
        bus.cmd_wdata = 32'h77;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFEF00D || bus.rsp_err !== 1'b0 ||
                bus.rsp_timeout !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d valid=%0b rdata=%h cmd_ready=%0b psel=%0b required 1/cafef00d/0/0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.cmd_ready, bus.psel);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0) begin
            failures++;
            $display("FAIL bp_release valid=%0b cmd_ready=%0b psel=%0b required 0/1/0",
                     bus.rsp_valid, bus.cmd_ready, bus.psel);
        end
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.psel !== 1'b1 || bus.paddr !== 32'h44 || bus.pwrite !== 1'b1 || bus.pwdata !== 32'h77) begin
            failures++;
            $display("FAIL bp_next_cmd psel=%0b paddr=%h pwrite=%0b pwdata=%h required 1/44/1/77",
                     bus.psel, bus.paddr, bus.pwrite, bus.pwdata);
        end
        bus.pready = 1'b1;
        tick();
        tick();
        bus.pready = 1'b0;
        finish_rsp("bp_next");
    endtask

    task automatic test_reset_mid_access();
        bus.pready = 1'b0;
        send_cmd(32'h8, 1'b0, 32'h0);
        tick();
        tick();
        checks++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre psel=%0b penable=%0b required 1/1", bus.psel, bus.penable);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_post psel=%0b penable=%0b rsp_valid=%0b cmd_ready=%0b required 0/0/0/0",
                     bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_ready got=%0b required=1", bus.cmd_ready);
        end
        tick();
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_no_rsp rsp_valid=%0b psel=%0b required 0/0", bus.rsp_valid, bus.psel);
        end
    endtask

    initial begin
        test_reset();
        test_write_fast();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_rsp_backpressure();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
